// File: rtl/winograd_output_transform.sv
// Winograd F(2x2,3x3) output stage: accumulates NCH product tiles (one per
// input channel) and then applies Y = A^T * M * A over two register stages,
// presenting one 2x2 output tile on a valid/ready stream.
module winograd_output_transform #(
    parameter  int PW   = 16,
    parameter  int ACCW = 24,
    parameter  int NCH  = 4,
    localparam int OW   = ACCW + 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [16*PW-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*OW-1:0]    out_data
);

    localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNTW-1:0] LAST_CH = CNTW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_XF1   = 2'd1,
        ST_XF2   = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNTW-1:0]         r_ch_cnt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [4*OW-1:0]         r_out_data;
    logic signed [ACCW-1:0]  r_acc [16];
    // r_t[0][c] = m0c+m1c+m2c, r_t[1][c] = m1c-m2c-m3c
    logic signed [OW-1:0]    r_t [2][4];
    logic signed [PW-1:0]    w_elem [16];
    logic signed [OW-1:0]    w_m [16];
    logic                    w_accept;
    logic                    w_last_beat;

    // in_ready mirrors "in ACCUM", so a beat can only land while accumulating
    assign w_accept    = in_valid && r_in_ready;
    assign w_last_beat = w_accept && (r_ch_cnt == LAST_CH);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Unpack incoming product elements and widen accumulators for the transform
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            w_elem[k] = in_data[k*PW +: PW];
            w_m[k]    = OW'(r_acc[k]);
        end
    end

    // Next-state logic for the accumulate / transform / output sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_XF1;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_XF1:   w_state_nxt = ST_XF2;
            ST_XF2:   w_state_nxt = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default:  w_state_nxt = ST_ACCUM;
        endcase
    end

    // State register plus handshake flags, registered from the next state
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_ACCUM);
            r_out_valid <= (w_state_nxt == ST_OUT);
        end
    end

    // Datapath: channel accumulation, column pass, row pass
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_ch_cnt   <= {CNTW{1'b0}};
            r_out_data <= {(4*OW){1'b0}};
            for (int k = 0; k < 16; k++) begin
                r_acc[k] <= {ACCW{1'b0}};
            end
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 4; c++) begin
                    r_t[i][c] <= {OW{1'b0}};
                end
            end
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        // First channel loads, discarding sums from the previous tile
                        for (int k = 0; k < 16; k++) begin
                            if (r_ch_cnt == {CNTW{1'b0}}) begin
                                r_acc[k] <= ACCW'(w_elem[k]);
                            end else begin
                                r_acc[k] <= r_acc[k] + ACCW'(w_elem[k]);
                            end
                        end
                        if (r_ch_cnt == LAST_CH) begin
                            r_ch_cnt <= {CNTW{1'b0}};
                        end else begin
                            r_ch_cnt <= r_ch_cnt + CNTW'(1);
                        end
                    end
                end
                ST_XF1: begin
                    for (int c = 0; c < 4; c++) begin
                        r_t[0][c] <= w_m[c] + w_m[4+c] + w_m[8+c];
                        r_t[1][c] <= w_m[4+c] - w_m[8+c] - w_m[12+c];
                    end
                end
                ST_XF2: begin
                    for (int r = 0; r < 2; r++) begin
                        r_out_data[(2*r)*OW +: OW]   <= r_t[r][0] + r_t[r][1] + r_t[r][2];
                        r_out_data[(2*r+1)*OW +: OW] <= r_t[r][1] - r_t[r][2] - r_t[r][3];
                    end
                end
                ST_OUT: begin
                    r_ch_cnt <= {CNTW{1'b0}};
                end
                default: begin
                    r_ch_cnt <= {CNTW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_winograd_output_transform.sv
// Directed bench for winograd_output_transform with hand-computed tiles.
module tb_winograd_output_transform;

    localparam int PW = 16;
    localparam int OW = 28;

    logic              clk;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [16*PW-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [4*OW-1:0]   out_data;

    int n_vec;
    int n_err;

    winograd_output_transform #(.PW(16), .ACCW(24), .NCH(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint y_el(input int k);
        logic signed [OW-1:0] v;
        v = out_data[k*OW +: OW];
        return longint'(v);
    endfunction

    function automatic logic [16*PW-1:0] tile_all(input int v);
        logic [16*PW-1:0] t;
        for (int k = 0; k < 16; k++) t[k*PW +: PW] = PW'(v);
        return t;
    endfunction

    function automatic logic [16*PW-1:0] tile_one(input int idx, input int v);
        logic [16*PW-1:0] t;
        t = {(16*PW){1'b0}};
        t[idx*PW +: PW] = PW'(v);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat after 'bubbles' idle cycles; returns 1ns after the accepting edge.
    task automatic send_beat(input string tag, input logic [16*PW-1:0] d, input int bubbles);
        bit done;
        in_valid = 1'b0;
        repeat (bubbles) tick();
        in_data  = d;
        in_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check_val({tag, "_accepted"}, longint'(done), 64'sd1);
        check_val({tag, "_no_out_valid"}, longint'(out_valid), 64'sd0);
    endtask

    // Called 1ns after the last accept; expects out_valid after exactly 2 edges.
    task automatic expect_tile(input string tag, input longint e00, input longint e01,
                               input longint e10, input longint e11);
        tick();
        check_val({tag, "_xf_busy_valid"}, longint'(out_valid), 64'sd0);
        check_val({tag, "_xf_busy_ready"}, longint'(in_ready), 64'sd0);
        tick();
        check_val({tag, "_out_valid"}, longint'(out_valid), 64'sd1);
        check_val({tag, "_y00"}, y_el(0), e00);
        check_val({tag, "_y01"}, y_el(1), e01);
        check_val({tag, "_y10"}, y_el(2), e10);
        check_val({tag, "_y11"}, y_el(3), e11);
    endtask

    task automatic finish_handshake(input string tag);
        out_ready = 1'b1;
        tick();
        check_val({tag, "_valid_drop"}, longint'(out_valid), 64'sd0);
        check_val({tag, "_ready_back"}, longint'(in_ready), 64'sd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rstn      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = {(16*PW){1'b0}};
        tick();
        tick();
        rstn = 1'b0;
        check_val("reset_out_valid", longint'(out_valid), 64'sd0);
        check_val("reset_in_ready", longint'(in_ready), 64'sd1);
        check_val("reset_out_data", longint'(out_data[63:0]), 64'sd0);

        // Test 1: all ones
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) send_beat("t1", tile_all(1), 0);
        expect_tile("t1", 64'sd36, -64'sd12, -64'sd12, 64'sd4);
        finish_handshake("t1");

        // Test 2: single element (1,1) in first channel only
        send_beat("t2", tile_one(5, 1), 0);
        for (int b = 0; b < 3; b++) send_beat("t2", tile_all(0), 0);
        expect_tile("t2", 64'sd1, 64'sd1, 64'sd1, 64'sd1);
        finish_handshake("t2");

        // Test 3: most negative product in every element
        for (int b = 0; b < 4; b++) send_beat("t3", tile_all(-32768), 0);
        expect_tile("t3", -64'sd1179648, 64'sd393216, 64'sd393216, -64'sd131072);
        finish_handshake("t3");

        // Test 4: back-pressure in OUT with in_valid held high
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) send_beat("t4", tile_all(1), 0);
        expect_tile("t4", 64'sd36, -64'sd12, -64'sd12, 64'sd4);
        in_data  = tile_all(9);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t4_hold_valid", longint'(out_valid), 64'sd1);
            check_val("t4_hold_ready", longint'(in_ready), 64'sd0);
            check_val("t4_hold_y00", y_el(0), 64'sd36);
            check_val("t4_hold_y11", y_el(3), 64'sd4);
        end
        finish_handshake("t4");
        in_valid = 1'b0;
        check_val("t4_data_kept", y_el(1), -64'sd12);
        // Leaked 9s from the hold phase would corrupt this tile
        for (int b = 0; b < 4; b++) send_beat("t4b", tile_all(1), 0);
        expect_tile("t4b", 64'sd36, -64'sd12, -64'sd12, 64'sd4);
        finish_handshake("t4b");

        // Test 5: bubbles between beats
        send_beat("t5", tile_all(1), 2);
        send_beat("t5", tile_all(1), 1);
        send_beat("t5", tile_all(1), 3);
        send_beat("t5", tile_all(1), 2);
        expect_tile("t5", 64'sd36, -64'sd12, -64'sd12, 64'sd4);
        finish_handshake("t5");

        // Test 6: reset after two accepted beats
        send_beat("t6", tile_all(7), 0);
        send_beat("t6", tile_all(7), 0);
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        check_val("t6_rst_valid", longint'(out_valid), 64'sd0);
        check_val("t6_rst_ready", longint'(in_ready), 64'sd1);
        check_val("t6_rst_data", y_el(0), 64'sd0);
        for (int b = 0; b < 4; b++) send_beat("t6", tile_all(1), 0);
        expect_tile("t6", 64'sd36, -64'sd12, -64'sd12, 64'sd4);
        finish_handshake("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
